// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline stage: valid/ready handshake with a 2-entry skid buffer.
// Carries NUM_WR register write lanes plus HI/LO, flags and LLbit sidebands.
// Lane writes are filtered on capture: a write to r0 can be dropped, and when
// two lanes target the same register only the highest-index lane keeps its enable.
// A saturating counter records every cycle in which WB back-pressures a held beat.
//
// state | meaning
// EMPTY | nothing held, outputs are all zero
// ONE   | main slot holds the beat presented to WB
// FULL  | main and skid slots both hold beats, input is back-pressured
module mem_wb_skid #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int NUM_WR       = 2,
   parameter int ZERO_DISCARD = 1,
   parameter int CNT_W        = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_WR*ADDR_W-1:0]   in_wd,
   input  logic [NUM_WR-1:0]          in_wreg,
   input  logic [NUM_WR*DATA_W-1:0]   in_wdata,
   input  logic [DATA_W-1:0]          in_hi,
   input  logic [DATA_W-1:0]          in_lo,
   input  logic                       in_hilo_we,
   input  logic [DATA_W-1:0]          in_flags,
   input  logic                       in_llbit_we,
   input  logic                       in_llbit_value,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_WR*ADDR_W-1:0]   out_wd,
   output logic [NUM_WR-1:0]          out_wreg,
   output logic [NUM_WR*DATA_W-1:0]   out_wdata,
   output logic [DATA_W-1:0]          out_hi,
   output logic [DATA_W-1:0]          out_lo,
   output logic                       out_hilo_we,
   output logic [DATA_W-1:0]          out_flags,
   output logic                       out_llbit_we,
   output logic                       out_llbit_value,
   output logic [1:0]                 occupancy,
   output logic [CNT_W-1:0]           stall_cnt
);

   // Flat payload layout, LSB first.
   localparam int WD_W    = NUM_WR * ADDR_W;
   localparam int WDATA_W = NUM_WR * DATA_W;
   localparam int O_WD    = 0;
   localparam int O_WREG  = O_WD + WD_W;
   localparam int O_WDATA = O_WREG + NUM_WR;
   localparam int O_HI    = O_WDATA + WDATA_W;
   localparam int O_LO    = O_HI + DATA_W;
   localparam int O_HWE   = O_LO + DATA_W;
   localparam int O_FLAGS = O_HWE + 1;
   localparam int O_LLWE  = O_FLAGS + DATA_W;
   localparam int O_LLV   = O_LLWE + 1;
   localparam int PW      = O_LLV + 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   main_q, skid_q, main_nxt, skid_nxt;
   logic [PW-1:0]   in_beat;
   logic [NUM_WR-1:0] wreg_f;
   logic            push, pop;

   // Capture filter: r0 discard and same-address conflicts (highest lane wins).
   always_comb begin
      wreg_f = in_wreg;
      for (int i = 0; i < NUM_WR; i++) begin
         if (ZERO_DISCARD != 0 && in_wd[i*ADDR_W +: ADDR_W] == '0)
            wreg_f[i] = 1'b0;
         for (int j = i + 1; j < NUM_WR; j++) begin
            if (in_wreg[i] && in_wreg[j] &&
                in_wd[i*ADDR_W +: ADDR_W] == in_wd[j*ADDR_W +: ADDR_W])
               wreg_f[i] = 1'b0;
         end
      end
   end

   assign in_beat = {in_llbit_value, in_llbit_we, in_flags, in_hilo_we,
                     in_lo, in_hi, in_wdata, wreg_f, in_wd};

   // in_ready decodes the state register only; reset forces it high.
   assign in_ready  = rst | (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Next-state and slot movement; emptied slots are zeroed so bubbles read as 0.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         state_nxt = EMPTY;
         main_nxt  = '0;
         skid_nxt  = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  state_nxt = ONE;
                  main_nxt  = in_beat;
               end
            end
            ONE: begin
               if (push && pop) begin
                  main_nxt = in_beat;
               end else if (push) begin
                  state_nxt = FULL;
                  skid_nxt  = in_beat;
               end else if (pop) begin
                  state_nxt = EMPTY;
                  main_nxt  = '0;
               end
            end
            FULL: begin
               if (pop) begin
                  state_nxt = ONE;
                  main_nxt  = skid_q;
                  skid_nxt  = '0;
               end
            end
            default: begin
               state_nxt = EMPTY;
               main_nxt  = '0;
               skid_nxt  = '0;
            end
         endcase
      end
   end

   // State and slot registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
      end
   end

   // Saturating back-pressure counter; a flush cycle leaves it untouched.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (!flush && out_valid && !out_ready && stall_cnt != '1)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

   // Occupancy decode.
   always_comb begin
      case (state)
         ONE:     occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   assign out_wd          = main_q[O_WD +: WD_W];
   assign out_wreg        = main_q[O_WREG +: NUM_WR];
   assign out_wdata       = main_q[O_WDATA +: WDATA_W];
   assign out_hi          = main_q[O_HI +: DATA_W];
   assign out_lo          = main_q[O_LO +: DATA_W];
   assign out_hilo_we     = main_q[O_HWE];
   assign out_flags       = main_q[O_FLAGS +: DATA_W];
   assign out_llbit_we    = main_q[O_LLWE];
   assign out_llbit_value = main_q[O_LLV];

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid: table of capture-filter vectors plus hand-written
// back-pressure, flush, reset and saturation sequences, all checked against
// a queue of expected beats.
module tb_mem_wb_skid;

   typedef struct packed {
      logic [9:0]  wd;
      logic [1:0]  wreg;
      logic [63:0] wdata;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        hwe;
      logic [31:0] flags;
      logic        llwe;
      logic        llv;
   } beat_t;

   typedef struct {
      beat_t      b;
      logic [1:0] exp_wreg;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [9:0]  in_wd, out_wd;
   logic [1:0]  in_wreg, out_wreg, occupancy;
   logic [63:0] in_wdata, out_wdata;
   logic [31:0] in_hi, in_lo, in_flags, out_hi, out_lo, out_flags;
   logic        in_hilo_we, in_llbit_we, in_llbit_value;
   logic        out_hilo_we, out_llbit_we, out_llbit_value;
   logic [3:0]  stall_cnt;

   beat_t out_b, exp_in;
   beat_t q[$];
   int    n_vec  = 0;
   int    n_miss = 0;
   vec_t  tbl[7];

   assign out_b = {out_wd, out_wreg, out_wdata, out_hi, out_lo, out_hilo_we,
                   out_flags, out_llbit_we, out_llbit_value};

   mem_wb_skid #(.DATA_W(32), .ADDR_W(5), .NUM_WR(2), .ZERO_DISCARD(1), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata), .in_hi(in_hi), .in_lo(in_lo),
      .in_hilo_we(in_hilo_we), .in_flags(in_flags), .in_llbit_we(in_llbit_we),
      .in_llbit_value(in_llbit_value), .out_valid(out_valid), .out_ready(out_ready),
      .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata), .out_hi(out_hi),
      .out_lo(out_lo), .out_hilo_we(out_hilo_we), .out_flags(out_flags),
      .out_llbit_we(out_llbit_we), .out_llbit_value(out_llbit_value),
      .occupancy(occupancy), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   function automatic beat_t mk(logic [4:0] wd1, logic [4:0] wd0, logic [1:0] wreg,
                                logic [31:0] seed);
      beat_t b;
      b.wd    = {wd1, wd0};
      b.wreg  = wreg;
      b.wdata = {seed ^ 32'h1111_0000, seed};
      b.hi    = seed + 32'd1;
      b.lo    = seed + 32'd2;
      b.hwe   = seed[0];
      b.flags = ~seed;
      b.llwe  = seed[1];
      b.llv   = seed[2];
      return b;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic chk_beat(string nm, beat_t act, beat_t exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic drive(beat_t b, logic [1:0] ew);
      in_wd          = b.wd;
      in_wreg        = b.wreg;
      in_wdata       = b.wdata;
      in_hi          = b.hi;
      in_lo          = b.lo;
      in_hilo_we     = b.hwe;
      in_flags       = b.flags;
      in_llbit_we    = b.llwe;
      in_llbit_value = b.llv;
      exp_in         = b;
      exp_in.wreg    = ew;
      in_valid       = 1'b1;
   endtask

   // One clock: check output against the scoreboard head, update the queue.
   task automatic cycle();
      logic do_push, do_pop;
      #1;
      if (out_valid) begin
         if (q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_beat: got %h, required no beat", out_b);
         end else begin
            chk_beat("beat", out_b, q[0]);
         end
      end else begin
         chk_beat("bubble", out_b, '0);
      end
      do_pop  = out_valid & out_ready;
      do_push = in_valid & in_ready;
      if (rst || flush) begin
         q.delete();
      end else begin
         if (do_pop && q.size() > 0) void'(q.pop_front());
         if (do_push) q.push_back(exp_in);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(int n);
      in_valid = 1'b0;
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      tbl[0] = '{mk(5'd7,  5'd7,  2'b11, 32'h0000_A001), 2'b10};
      tbl[1] = '{mk(5'd5,  5'd0,  2'b11, 32'h0000_A002), 2'b10};
      tbl[2] = '{mk(5'd9,  5'd4,  2'b11, 32'h0000_A003), 2'b11};
      tbl[3] = '{mk(5'd0,  5'd0,  2'b11, 32'h0000_A004), 2'b00};
      tbl[4] = '{mk(5'd6,  5'd6,  2'b01, 32'h0000_A005), 2'b01};
      tbl[5] = '{mk(5'd0,  5'd12, 2'b10, 32'h0000_A006), 2'b00};
      tbl[6] = '{mk(5'd31, 5'd30, 2'b00, 32'h0000_A007), 2'b00};

      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive('0, 2'b00);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("ready_in_rst", 64'(in_ready), 64'd1);
      rst = 1'b0;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_stall", 64'(stall_cnt), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk_beat("rst_payload", out_b, '0);

      // Single beat, one-cycle latency, then bubble.
      drive(mk(5'd0, 5'd3, 2'b01, 32'hDEAD_BEEF), 2'b01);
      cycle();
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_wdata", 64'(out_wdata[31:0]), 64'hDEAD_BEEF);
      idle(1);
      chk("single_drain", 64'(out_valid), 64'd0);
      chk_beat("single_zero", out_b, '0);

      // Filter vectors streamed back-to-back at full throughput.
      for (int v = 0; v < 7; v++) begin
         drive(tbl[v].b, tbl[v].exp_wreg);
         cycle();
         chk("stream_valid", 64'(out_valid), 64'd1);
         chk("stream_occ", 64'(occupancy), 64'd1);
         chk("stream_wreg", 64'(out_wreg), 64'(tbl[v].exp_wreg));
      end
      idle(2);

      // Back-pressure: A and B taken, C refused, then drained in order.
      out_ready = 1'b0;
      drive(mk(5'd0, 5'd3, 2'b01, 32'h1), 2'b01);
      cycle();
      drive(mk(5'd0, 5'd3, 2'b01, 32'h2), 2'b01);
      cycle();
      drive(mk(5'd0, 5'd3, 2'b01, 32'h3), 2'b01);
      chk("bp_ready_c", 64'(in_ready), 64'd0);
      chk("bp_occ", 64'(occupancy), 64'd2);
      cycle();
      chk("bp_stall", 64'(stall_cnt), 64'd2);
      out_ready = 1'b1;
      cycle();
      chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
      cycle();
      idle(2);
      chk("bp_queue_empty", 64'(q.size()), 64'd0);
      chk("bp_stall_hold", 64'(stall_cnt), 64'd2);

      // Flush while FULL with a beat offered.
      out_ready = 1'b0;
      drive(mk(5'd1, 5'd2, 2'b11, 32'h0000_F001), 2'b11);
      cycle();
      drive(mk(5'd1, 5'd2, 2'b11, 32'h0000_F002), 2'b11);
      cycle();
      chk("fl_occ_full", 64'(occupancy), 64'd2);
      drive(mk(5'd1, 5'd2, 2'b11, 32'h0000_F003), 2'b11);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_occ", 64'(occupancy), 64'd0);
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_ready", 64'(in_ready), 64'd1);
      chk("fl_stall", 64'(stall_cnt), 64'd3);
      out_ready = 1'b1;
      idle(3);

      // Reset mid-stream with two beats held and stall_cnt at 5.
      out_ready = 1'b0;
      drive(mk(5'd8, 5'd9, 2'b11, 32'h0000_5001), 2'b11);
      cycle();
      drive(mk(5'd8, 5'd9, 2'b11, 32'h0000_5002), 2'b11);
      cycle();
      idle(1);
      chk("rs_pre_stall", 64'(stall_cnt), 64'd5);
      chk("rs_pre_occ", 64'(occupancy), 64'd2);
      rst = 1'b1;
      #1;
      chk("rs_ready_in_rst", 64'(in_ready), 64'd1);
      cycle();
      rst = 1'b0;
      chk("rs_valid", 64'(out_valid), 64'd0);
      chk("rs_occ", 64'(occupancy), 64'd0);
      chk("rs_stall", 64'(stall_cnt), 64'd0);
      chk("rs_ready", 64'(in_ready), 64'd1);
      chk_beat("rs_payload", out_b, '0);

      // Counter saturation at 4 bits.
      drive(mk(5'd2, 5'd1, 2'b11, 32'h0000_C001), 2'b11);
      cycle();
      idle(14);
      chk("sat_14", 64'(stall_cnt), 64'd14);
      idle(6);
      chk("sat_full", 64'(stall_cnt), 64'hF);
      idle(1);
      chk("sat_stick", 64'(stall_cnt), 64'hF);
      out_ready = 1'b1;
      idle(2);
      chk("sat_drained", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
